mult_seq_ctrl: RTL and testbench

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

---
 rtl/mult_seq_ctrl_if.sv | 33 +++
 rtl/mult_seq_ctrl.sv | 115 +++++++++++
 tb/tb_mult_seq_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mult_seq_ctrl_if.sv
// Bundles the multiply-control signals between the decode/execute pipeline
// and the sequential multiplier controller.
// The master side is the pipeline that drives decode information. The slave
// side is the controller that returns the start, stall and write controls.
interface mult_seq_ctrl_if;
    // Decode-stage information and the external stall source
    logic        start_mult_d;
    logic        mult_sign_d;
    logic [1:0]  outselect_d;
    logic        stall_in;

    // Controller outputs
    logic        mult_start_e;
    logic        mult_sign_e;
    logic        hilo_we;
    logic        stall_f;
    logic        stall_d;
    logic        flush_e;
    logic        mult_busy;
    logic [15:0] stall_cnt;

    modport master (
        output start_mult_d, mult_sign_d, outselect_d, stall_in,
        input  mult_start_e, mult_sign_e, hilo_we, stall_f, stall_d,
               flush_e, mult_busy, stall_cnt
    );

    modport slave (
        input  start_mult_d, mult_sign_d, outselect_d, stall_in,
        output mult_start_e, mult_sign_e, hilo_we, stall_f, stall_d,
               flush_e, mult_busy, stall_cnt
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequential multiplier controller. It runs a three-state FSM
// (IDLE -> BUSY -> DONE) that issues one start pulse, waits a fixed number
// of cycles (MULT_LATENCY), and then pulses the HI/LO write enable.
// While an operation is in flight, a dependent decode-stage instruction
// stalls fetch and decode and inserts a bubble into execute.
// Optional feature: define MULT_STALL_CNT_EN to build a saturating 16-bit
// counter of hazard-stall cycles. Without it, stall_cnt reads as zero.
module mult_seq_ctrl #(
    parameter int MULT_LATENCY = 32   // BUSY cycles per operation, 2..63
) (
    input  logic              clk,
    input  logic              reset,
    mult_seq_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The counter is loaded with LATENCY-1. BUSY ends on the cycle where it
    // reads zero, so BUSY lasts exactly MULT_LATENCY cycles.
    localparam logic [5:0] LAT_M1 = 6'(MULT_LATENCY - 1);

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_mult_start;
    logic        r_mult_sign;
    logic        r_hilo_we;
    logic [15:0] w_stall_cnt;

    logic        w_accept;
    logic        w_busy;
    logic        w_dep;
    logic        w_hazard;

    // The external stall only gates acceptance. Once the operation is
    // running, its duration is fixed.
    assign w_accept = (r_state == S_IDLE) && bus.start_mult_d && !bus.stall_in;
    assign w_busy   = (r_state == S_BUSY) || (r_state == S_DONE);

    // These decode instructions need the multiplier: another multiply, or a
    // read of HI or LO. ALU results and other selects are independent.
    assign w_dep    = bus.start_mult_d
                   || (bus.outselect_d == 2'b01)
                   || (bus.outselect_d == 2'b10);
    assign w_hazard = w_busy && w_dep;

    // Main FSM. The start pulse and the HI/LO write are registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 6'd0;
            r_mult_start <= 1'b0;
            r_mult_sign  <= 1'b0;
            r_hilo_we    <= 1'b0;
        end else begin
            r_mult_start <= 1'b0;
            r_hilo_we    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state      <= S_BUSY;
                        r_cnt        <= LAT_M1;
                        r_mult_sign  <= bus.mult_sign_d;
                        r_mult_start <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 6'd0) begin
                        r_state   <= S_DONE;
                        r_hilo_we <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MULT_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Count every hazard-stall cycle. The count sticks at all-ones and is
    // cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 16'd0;
        end else if (w_hazard && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign w_stall_cnt = r_stall_cnt;
`else
    assign w_stall_cnt = 16'd0;
`endif

    assign bus.mult_start_e = r_mult_start;
    assign bus.mult_sign_e  = r_mult_sign;
    assign bus.hilo_we      = r_hilo_we;
    assign bus.stall_f      = w_hazard;
    assign bus.stall_d      = w_hazard;
    assign bus.flush_e      = w_hazard;
    assign bus.mult_busy    = w_busy;
    assign bus.stall_cnt    = w_stall_cnt;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Testbench for mult_seq_ctrl. It runs directed scenarios followed by
// randomized traffic. A reference model tracks each operation as
// "cycles since accept" and checks every output every cycle.
// It honours MULT_STALL_CNT_EN in the same way as the design.
module tb_mult_seq_ctrl;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mult_seq_ctrl_if bus();

    mult_seq_ctrl #(.MULT_LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state. age = 0 means idle. age = 1..LAT means busy.
    // age = LAT+1 is the done/write cycle.
    int   age;
    logic m_sign;
    int   m_scnt;
    int   n_ops;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Check all outputs at mid-cycle, then advance the model across the
    // next rising edge.
    task automatic step();
        logic hz;
        @(negedge clk);
        hz = (age != 0) && (bus.start_mult_d || bus.outselect_d == 2'b01 ||
                            bus.outselect_d == 2'b10);
        check_val("mult_busy",    32'(bus.mult_busy),    32'(age != 0));
        check_val("mult_start_e", 32'(bus.mult_start_e), 32'(age == 1));
        check_val("hilo_we",      32'(bus.hilo_we),      32'(age == LAT + 1));
        check_val("mult_sign_e",  32'(bus.mult_sign_e),  32'(m_sign));
        check_val("stall_f",      32'(bus.stall_f),      32'(hz));
        check_val("stall_d",      32'(bus.stall_d),      32'(hz));
        check_val("flush_e",      32'(bus.flush_e),      32'(hz));
        check_val("stall_cnt",    32'(bus.stall_cnt),    32'(m_scnt));
        if (reset) begin
            age    = 0;
            m_sign = 1'b0;
            m_scnt = 0;
        end else begin
`ifdef MULT_STALL_CNT_EN
            if (hz && m_scnt < 65535) m_scnt++;
`endif
            if (age == 0) begin
                if (bus.start_mult_d && !bus.stall_in) begin
                    age    = 1;
                    m_sign = bus.mult_sign_d;
                    n_ops++;
                    $display("op %0d accepted sign=%0d t=%0t", n_ops, m_sign, $time);
                end
            end else if (age == LAT + 1) begin
                age = 0;
            end else begin
                age++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic s, input logic sg, input logic [1:0] os,
                       input logic st, input logic rs);
        bus.start_mult_d = s;
        bus.mult_sign_d  = sg;
        bus.outselect_d  = os;
        bus.stall_in     = st;
        reset            = rs;
        step();
    endtask

    int exp_total;

    initial begin
        n_ops  = 0;
        age    = 0;
        m_sign = 1'b0;
        m_scnt = 0;
        reset  = 1'b1;
        bus.start_mult_d = 1'b0;
        bus.mult_sign_d  = 1'b0;
        bus.outselect_d  = 2'b00;
        bus.stall_in     = 1'b0;
        @(posedge clk);
        #1;
        cyc(0, 0, 2'b00, 0, 1);    // check the reset state
        cyc(0, 0, 2'b01, 0, 0);    // idle HI read: no stall

        // Basic op, with a HI read held from cycle 2 through cycle 6
        cyc(1, 0, 2'b00, 0, 0);    // cycle 0: accept
        cyc(0, 0, 2'b00, 0, 0);    // cycle 1
        for (int i = 2; i <= 6; i++) cyc(0, 0, 2'b01, 0, 0);

        // Independent selects during BUSY must not stall, and stall_in is
        // ignored there
        cyc(1, 0, 2'b00, 0, 0);
        for (int i = 0; i < LAT + 1; i++) cyc(0, 0, 2'(i % 2 ? 3 : 0), 1, 0);
        cyc(0, 0, 2'b00, 0, 0);

        // Blocked accept for 3 cycles, then release
        for (int i = 0; i < 3; i++) cyc(1, 0, 2'b00, 1, 0);
        cyc(1, 0, 2'b00, 0, 0);
        for (int i = 0; i < LAT + 2; i++) cyc(0, 0, 2'b00, 0, 0);

        // Sign latch: accept signed, toggle sign during BUSY
        cyc(1, 1, 2'b00, 0, 0);
        for (int i = 0; i < LAT + 2; i++) cyc(0, 1'(i % 2), 2'b00, 0, 0);
        cyc(1, 0, 2'b00, 0, 0);    // next accept, unsigned
        for (int i = 0; i < LAT + 2; i++) cyc(0, 1, 2'b00, 0, 0);

        // Reset in the third BUSY cycle aborts the op without a HI/LO write
        cyc(1, 1, 2'b00, 0, 0);
        cyc(0, 0, 2'b00, 0, 0);
        cyc(0, 0, 2'b00, 0, 0);
        cyc(0, 0, 2'b10, 0, 1);
        for (int i = 0; i < LAT + 2; i++) cyc(0, 0, 2'b10, 0, 0);

        // Two multiplies, each with a dependent LO read for 4 stall cycles
        cyc(0, 0, 2'b00, 0, 1);
        for (int r = 0; r < 2; r++) begin
            cyc(1, 0, 2'b00, 0, 0);
            cyc(0, 0, 2'b00, 0, 0);
            for (int i = 0; i < 4; i++) cyc(0, 0, 2'b10, 0, 0);
            cyc(0, 0, 2'b00, 0, 0);
        end
`ifdef MULT_STALL_CNT_EN
        exp_total = 8;
`else
        exp_total = 0;
`endif
        check_val("stall_cnt_total", 32'(bus.stall_cnt), 32'(exp_total));

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            cyc(1'($urandom_range(0, 2) == 0), 1'($urandom),
                2'($urandom), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 60) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
